// File: rtl/sram_port_pkg.sv
// Shared constants and helpers for the single-port SRAM initiator.
package sram_port_pkg;

    // Idle levels of the active-low macro pins
    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;

    // Width of the optional accepted-read/accepted-write counters
    localparam int unsigned STATS_W = 16;

    // Bits needed to hold a credit count in 0..max_credits
    function automatic int unsigned credit_w(input int unsigned max_credits);
        return (max_credits < 2) ? 1 : $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through response FIFO; depth need not be a power of two.
module sram_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_push,
    input  logic                             i_pop,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_valid,
    output logic [$clog2(RSP_DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Pointer increment with wrap at RSP_DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy; a full push is legal only with a pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    // Credit flow control must make these impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && (r_count == CNT_W'(RSP_DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && (r_count == '0)));

endmodule

// File: rtl/sram_port0_initiator.sv
// Initiator for one OpenRAM single-port macro port: request stream to registered
// pins, fixed-latency read capture, credit-protected response stream.
// Optional accepted-request counters enabled by SRAM_PORT_STATS_EN.
module sram_port0_initiator
    import sram_port_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 2,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RSP_DEPTH    = 2
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
`ifdef SRAM_PORT_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [STATS_W-1:0]    rd_count,
    output logic [STATS_W-1:0]    wr_count
`endif
);

    localparam int unsigned CRED_W = credit_w(RSP_DEPTH + READ_LATENCY);
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

    logic                  w_accept;
    logic                  w_acc_rd;
    logic                  w_push;
    logic                  w_pop;
    logic [CRED_W-1:0]     w_credits_nxt;
    logic                  w_fifo_valid;
    logic [DATA_WIDTH-1:0] w_fifo_rdata;
    logic [CNT_W-1:0]      w_fifo_count;

    logic [CRED_W-1:0]     r_credits;
    logic                  r_req_ready;
    logic [READ_LATENCY:0] r_rd_pipe;
    logic                  r_csb0;
    logic                  r_web0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;

    assign w_accept = req_valid && r_req_ready;
    assign w_acc_rd = w_accept && !req_we;
    assign w_push   = r_rd_pipe[READ_LATENCY];
    assign w_pop    = w_fifo_valid && rsp_ready;

    // Credits drop when a read is launched and return when its response is taken
    always_comb begin
        w_credits_nxt = r_credits;
        if (w_acc_rd) begin
            w_credits_nxt = w_credits_nxt - CRED_W'(1);
        end
        if (w_pop) begin
            w_credits_nxt = w_credits_nxt + CRED_W'(1);
        end
    end

    // Credit counter and registered ready, low throughout reset
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_credits   <= CRED_W'(RSP_DEPTH);
            r_req_ready <= 1'b0;
        end else begin
            r_credits   <= w_credits_nxt;
            r_req_ready <= (w_credits_nxt != '0);
        end
    end

    // Is-read shift register; the tail bit marks dout0 as ready to capture
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[READ_LATENCY-1:0], w_acc_rd};
        end
    end

    // Macro pin registers; din0 only changes on writes
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_csb0  <= CSB_IDLE;
            r_web0  <= WEB_IDLE;
            r_addr0 <= '0;
            r_din0  <= '0;
        end else if (w_accept) begin
            r_csb0  <= ~CSB_IDLE;
            r_web0  <= ~req_we;
            r_addr0 <= req_addr;
            if (req_we) begin
                r_din0 <= req_wdata;
            end
        end else begin
            r_csb0  <= CSB_IDLE;
            r_web0  <= WEB_IDLE;
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk0),
        .rst     (rst0),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (dout0),
        .o_rdata (w_fifo_rdata),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign req_ready = r_req_ready;
    assign rsp_valid = w_fifo_valid;
    assign rsp_rdata = w_fifo_rdata;
    assign csb0      = r_csb0;
    assign web0      = r_web0;
    assign addr0     = r_addr0;
    assign din0      = r_din0;

    // Queued responses plus free credits never exceed the FIFO depth
    a_credit_bound: assert property (@(posedge clk0) disable iff (rst0)
        (32'(r_credits) + 32'(w_fifo_count)) <= RSP_DEPTH);

`ifdef SRAM_PORT_STATS_EN
    logic                  w_acc_wr;
    logic [STATS_W-1:0]    r_rd_count;
    logic [STATS_W-1:0]    r_wr_count;

    assign w_acc_wr = w_accept && req_we;

    // Saturating accepted-request counters; clear wins over increment
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (stats_clr) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_acc_rd && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + STATS_W'(1);
            end
            if (w_acc_wr && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + STATS_W'(1);
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule
